// File: rtl/xbar_reg_n.sv
// Registered N-port crossbar: per-output one-hot select, one register stage,
// valid tracking, hold enable, sticky illegal-select flag and saturating flit counter.
module xbar_reg_n #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_PORTS      = 5,
  parameter int LEGACY_DEFAULT = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_PORTS-1:0]            valid_in,
  input  logic [NUM_PORTS*NUM_PORTS-1:0]  sel,
  input  logic [NUM_PORTS-1:0]            out_en,
  input  logic                            err_clr,
  input  logic                            cnt_clr,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] data_out,
  output logic [NUM_PORTS-1:0]            valid_out,
  output logic [NUM_PORTS-1:0]            sel_err,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]  flit_cnt
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam logic [NUM_PORTS-1:0] SEL_ONE = NUM_PORTS'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] din_arr [NUM_PORTS];

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_din
    assign din_arr[gi] = data_in[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_out
    logic [NUM_PORTS-1:0]  sel_w;
    logic [IDX_W-1:0]      src;
    logic                  has_src;
    logic                  multi_hot;
    logic                  src_valid;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    assign sel_w     = sel[gi*NUM_PORTS +: NUM_PORTS];
    // x & (x-1) is nonzero exactly when more than one bit is set
    assign multi_hot = |(sel_w & (sel_w - SEL_ONE));

    // Lowest set bit wins; an all-zero select falls back to the last port when legacy mode is on
    always_comb begin
      src     = IDX_W'(NUM_PORTS - 1);
      has_src = (LEGACY_DEFAULT != 0);
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (sel_w[i]) begin
          src     = IDX_W'(i);
          has_src = 1'b1;
        end
      end
    end

    assign src_valid = has_src & valid_in[src];

    always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      err_d   = multi_hot | (err_q & ~err_clr);
      if (out_en[gi]) begin
        valid_d = src_valid;
        if (src_valid) data_d = din_arr[src];
      end
      if (cnt_clr) begin
        cnt_d = '0;
      end else if (out_en[gi] && src_valid && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        data_q  <= '0;
        valid_q <= 1'b0;
        err_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
        err_q   <= err_d;
        cnt_q   <= cnt_d;
      end
    end

    assign data_out[gi*DATA_WIDTH +: DATA_WIDTH] = data_q;
    assign valid_out[gi]                         = valid_q;
    assign sel_err[gi]                           = err_q;
    assign flit_cnt[gi*CNT_WIDTH +: CNT_WIDTH]   = cnt_q;
  end

endmodule

// File: tb/tb_xbar_reg_n.sv
// Randomised bench for xbar_reg_n: three instances (legacy default, no default,
// 4-bit counters) share stimulus and are checked against a behavioural model.
module tb_xbar_reg_n;
  localparam int N  = 5;
  localparam int DW = 32;
  localparam int NC = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [DW-1:0] din_a [N];
  logic [N-1:0]  sel_a [N];
  logic [N-1:0]  vin, en;
  logic          err_clr, cnt_clr;
  logic [N*DW-1:0] din_p;
  logic [N*N-1:0]  sel_p;

  always_comb begin
    din_p = '0;
    sel_p = '0;
    for (int i = 0; i < N; i++) begin
      din_p[i*DW +: DW] = din_a[i];
      sel_p[i*N +: N]   = sel_a[i];
    end
  end

  logic [N*DW-1:0] dout [NC];
  logic [N-1:0]    vout [NC];
  logic [N-1:0]    serr [NC];
  logic [N*16-1:0] cnt_w0, cnt_w1;
  logic [N*4-1:0]  cnt_w2;

  xbar_reg_n u0 (
    .clk(clk), .reset(reset), .data_in(din_p), .valid_in(vin), .sel(sel_p),
    .out_en(en), .err_clr(err_clr), .cnt_clr(cnt_clr),
    .data_out(dout[0]), .valid_out(vout[0]), .sel_err(serr[0]), .flit_cnt(cnt_w0));
  xbar_reg_n #(.LEGACY_DEFAULT(0)) u1 (
    .clk(clk), .reset(reset), .data_in(din_p), .valid_in(vin), .sel(sel_p),
    .out_en(en), .err_clr(err_clr), .cnt_clr(cnt_clr),
    .data_out(dout[1]), .valid_out(vout[1]), .sel_err(serr[1]), .flit_cnt(cnt_w1));
  xbar_reg_n #(.CNT_WIDTH(4)) u2 (
    .clk(clk), .reset(reset), .data_in(din_p), .valid_in(vin), .sel(sel_p),
    .out_en(en), .err_clr(err_clr), .cnt_clr(cnt_clr),
    .data_out(dout[2]), .valid_out(vout[2]), .sel_err(serr[2]), .flit_cnt(cnt_w2));

  // Reference model state, one set per instance configuration
  logic [DW-1:0] m_data  [NC][N];
  bit            m_valid [NC][N];
  bit            m_err   [NC][N];
  int            m_cnt   [NC][N];
  int            cnt_max [NC] = '{65535, 65535, 15};
  bit            legacy  [NC] = '{1'b1, 1'b0, 1'b1};

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [DW-1:0] dut_data(int c, int o);
    return dout[c][o*DW +: DW];
  endfunction

  function automatic int dut_cnt(int c, int o);
    case (c)
      0:       return int'(cnt_w0[o*16 +: 16]);
      1:       return int'(cnt_w1[o*16 +: 16]);
      default: return int'(cnt_w2[o*4 +: 4]);
    endcase
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NC; c++)
      for (int o = 0; o < N; o++) begin
        m_data[c][o] = '0; m_valid[c][o] = 0; m_err[c][o] = 0; m_cnt[c][o] = 0;
      end
  endtask

  task automatic model_edge();
    for (int c = 0; c < NC; c++) begin
      for (int o = 0; o < N; o++) begin
        int  k   = $countones(sel_a[o]);
        int  src = N - 1;
        bit  have = 1;
        bit  nv;
        if (k > 1) m_err[c][o] = 1;
        else if (err_clr) m_err[c][o] = 0;
        if (k == 0) have = legacy[c];
        else begin
          for (int i = 0; i < N; i++) if (sel_a[o][i]) begin src = i; break; end
        end
        nv = have && vin[src];
        if (cnt_clr) m_cnt[c][o] = 0;
        else if (en[o] && nv && m_cnt[c][o] < cnt_max[c]) m_cnt[c][o]++;
        if (en[o]) begin
          m_valid[c][o] = nv;
          if (nv) m_data[c][o] = din_a[src];
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] rand_sel();
    int r = $urandom_range(0, 9);
    if (r < 7) return N'(1) << $urandom_range(0, N - 1);
    if (r == 7) return '0;
    return N'($urandom);
  endfunction

  task automatic test_reset();
    reset = 1'b0; vin = '0; en = '1; err_clr = 0; cnt_clr = 0;
    for (int i = 0; i < N; i++) begin din_a[i] = $urandom; sel_a[i] = N'(1) << i; end
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < NC; c++) begin
      n_checks++;
      if (dout[c] !== '0 || vout[c] !== '0 || serr[c] !== '0 || dut_cnt(c, 0) != 0)
        $display("FAIL reset c=%0d data=%h valid=%b err=%b cnt0=%0d exp all zero",
                 c, dout[c], vout[c], serr[c], dut_cnt(c, 0));
      else n_pass++;
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_onehot();
    for (int i = 0; i < N; i++) begin
      din_a[i] = 32'hA0 + i;
      sel_a[i] = N'(1) << ((i + 1) % N);
    end
    vin = '1; en = '1;
    tick();
    for (int o = 0; o < N; o++) begin
      n_checks++;
      if (dut_data(0, o) !== 32'hA0 + ((o + 1) % N))
        $display("FAIL onehot_data o=%0d got=%h exp=%h", o, dut_data(0, o), 32'hA0 + ((o + 1) % N));
      else n_pass++;
      n_checks++;
      if (dut_cnt(0, o) != 1 || dut_cnt(2, o) != 1)
        $display("FAIL onehot_cnt o=%0d got=%0d/%0d exp=1", o, dut_cnt(0, o), dut_cnt(2, o));
      else n_pass++;
    end
    n_checks++;
    if (vout[0] !== 5'b11111 || serr[0] !== 5'b00000)
      $display("FAIL onehot_valid got valid=%b err=%b exp 11111/00000", vout[0], serr[0]);
    else n_pass++;
  endtask

  task automatic test_multihot();
    sel_a[2] = 5'b10110;
    tick();
    n_checks++;
    if (dut_data(0, 2) !== 32'hA1 || serr[0][2] !== 1'b1)
      $display("FAIL multihot data=%h err=%b exp=%h/1", dut_data(0, 2), serr[0][2], 32'hA1);
    else n_pass++;
    sel_a[2] = 5'b01000;
    tick();
    n_checks++;
    if (serr[0][2] !== 1'b1) $display("FAIL err_sticky got=%b exp=1", serr[0][2]);
    else n_pass++;
    err_clr = 1;
    tick();
    n_checks++;
    if (serr[0][2] !== 1'b0) $display("FAIL err_clear got=%b exp=0", serr[0][2]);
    else n_pass++;
    sel_a[2] = 5'b10110;
    tick();
    n_checks++;
    if (serr[0][2] !== 1'b1) $display("FAIL err_clr_vs_new got=%b exp=1", serr[0][2]);
    else n_pass++;
    err_clr = 0;
    sel_a[2] = 5'b01000;
  endtask

  task automatic test_zero_sel();
    logic [DW-1:0] prev_d;
    int prev_c;
    sel_a[0] = '0; din_a[4] = 32'hDEAD; vin[4] = 1'b1;
    prev_d = m_data[1][0];
    prev_c = m_cnt[1][0];
    tick();
    n_checks++;
    if (dut_data(0, 0) !== 32'hDEAD || vout[0][0] !== 1'b1 || serr[0][0] !== 1'b0)
      $display("FAIL zero_legacy data=%h valid=%b err=%b exp=0000dead/1/0",
               dut_data(0, 0), vout[0][0], serr[0][0]);
    else n_pass++;
    n_checks++;
    if (vout[1][0] !== 1'b0 || dut_data(1, 0) !== prev_d || dut_cnt(1, 0) != prev_c)
      $display("FAIL zero_nodefault valid=%b data=%h cnt=%0d exp=0/%h/%0d",
               vout[1][0], dut_data(1, 0), dut_cnt(1, 0), prev_d, prev_c);
    else n_pass++;
    sel_a[0] = 5'b00010;
  endtask

  task automatic test_hold();
    logic [DW-1:0] hd;
    int hc;
    hd = m_data[0][3];
    hc = m_cnt[0][3];
    en[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++) begin din_a[i] = $urandom; sel_a[i] = N'(1) << $urandom_range(0, N - 1); end
      vin = N'($urandom) | 5'b00001;
      tick();
      n_checks++;
      if (dut_data(0, 3) !== hd || dut_cnt(0, 3) != hc || vout[0][3] !== m_valid[0][3])
        $display("FAIL hold k=%0d data=%h cnt=%0d exp=%h/%0d", k, dut_data(0, 3), dut_cnt(0, 3), hd, hc);
      else n_pass++;
    end
    en = '1;
  endtask

  task automatic test_invalid();
    vin = '0;
    for (int i = 0; i < N; i++) din_a[i] = $urandom;
    tick();
    for (int c = 0; c < NC; c++) begin
      for (int o = 0; o < N; o++) begin
        n_checks++;
        if (vout[c][o] !== 1'b0 || dut_data(c, o) !== m_data[c][o])
          $display("FAIL invalid c=%0d o=%0d valid=%b data=%h exp=0/%h",
                   c, o, vout[c][o], dut_data(c, o), m_data[c][o]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < N; i++) sel_a[i] = N'(1) << i;
    vin = '1; en = '1; cnt_clr = 1;
    tick();
    n_checks++;
    if (cnt_w2 !== '0 || cnt_w0 !== '0) $display("FAIL cnt_clr_prio got=%h/%h exp=0", cnt_w2, cnt_w0);
    else n_pass++;
    cnt_clr = 0;
    repeat (20) tick();
    for (int o = 0; o < N; o++) begin
      n_checks++;
      if (dut_cnt(2, o) != 15 || dut_cnt(0, o) != 20)
        $display("FAIL saturate o=%0d got=%0d/%0d exp=15/20", o, dut_cnt(2, o), dut_cnt(0, o));
      else n_pass++;
    end
    cnt_clr = 1;
    tick();
    n_checks++;
    if (cnt_w2 !== '0) $display("FAIL cnt_clr got=%h exp=0", cnt_w2);
    else n_pass++;
    cnt_clr = 0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N; i++) begin din_a[i] = $urandom; sel_a[i] = rand_sel(); end
      vin     = N'($urandom);
      en      = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      err_clr = ($urandom_range(0, 7) == 0);
      cnt_clr = ($urandom_range(0, 31) == 0);
      tick();
      for (int c = 0; c < NC; c++) begin
        for (int o = 0; o < N; o++) begin
          n_checks++;
          if (dut_data(c, o) !== m_data[c][o] || vout[c][o] !== m_valid[c][o] ||
              serr[c][o] !== m_err[c][o] || dut_cnt(c, o) != m_cnt[c][o])
            $display("FAIL random k=%0d c=%0d o=%0d got d=%h v=%b e=%b n=%0d exp d=%h v=%b e=%b n=%0d",
                     k, c, o, dut_data(c, o), vout[c][o], serr[c][o], dut_cnt(c, o),
                     m_data[c][o], m_valid[c][o], m_err[c][o], m_cnt[c][o]);
          else n_pass++;
        end
      end
    end
    err_clr = 0; cnt_clr = 0; en = '1;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < N; i++) begin din_a[i] = $urandom; sel_a[i] = N'(1) << i; end
    vin = '1;
    repeat (3) tick();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    for (int c = 0; c < NC; c++) begin
      n_checks++;
      if (dout[c] !== '0 || vout[c] !== '0 || serr[c] !== '0 || dut_cnt(c, 1) != 0)
        $display("FAIL async_reset c=%0d data=%h valid=%b exp zero", c, dout[c], vout[c]);
      else n_pass++;
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin din_a[i] = 32'hC0DE0000 + i; sel_a[i] = N'(1) << ((i + 2) % N); end
    #1;
    n_checks++;
    if (vout[0] !== '0) $display("FAIL post_reset_early valid=%b exp=00000", vout[0]);
    else n_pass++;
    tick();
    for (int o = 0; o < N; o++) begin
      n_checks++;
      if (dut_data(0, o) !== 32'hC0DE0000 + ((o + 2) % N) || vout[0][o] !== 1'b1 || dut_cnt(0, o) != 1)
        $display("FAIL post_reset_flit o=%0d got=%h v=%b n=%0d exp=%h/1/1", o, dut_data(0, o),
                 vout[0][o], dut_cnt(0, o), 32'hC0DE0000 + ((o + 2) % N));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_multihot();
    test_zero_sel();
    test_hold();
    test_invalid();
    test_saturation();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
